// File: rtl/demultiplexer3_stream.sv
// Registered 1-to-3 stream demultiplexer: each route owns a one-entry output slot,
// illegal route code 2'b11 is consumed and counted in a sticky, saturating error log.
module demultiplexer3_stream #(
    parameter int width        = 32,
    parameter int errcnt_width = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              control,
    input  logic [width-1:0]        in_data,
    output logic                    out_valid1,
    output logic                    out_valid2,
    output logic                    out_valid3,
    input  logic                    out_ready1,
    input  logic                    out_ready2,
    input  logic                    out_ready3,
    output logic [width-1:0]        out_data1,
    output logic [width-1:0]        out_data2,
    output logic [width-1:0]        out_data3,
    output logic                    err,
    output logic [errcnt_width-1:0] err_count,
    input  logic                    err_clear
);

    function automatic logic [errcnt_width-1:0] sat_inc(input logic [errcnt_width-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [2:0]             vld_p1;
    logic [width-1:0]       data_p1 [3];
    logic [2:0]             ready;
    logic [2:0]             slot_free;
    logic                   in_xfer;
    logic                   illegal;
    logic                   err_p1;
    logic [errcnt_width-1:0] cnt_p1;

    assign ready     = {out_ready3, out_ready2, out_ready1};
    // A full slot that drains this cycle can take a new word in the same cycle.
    assign slot_free = ~vld_p1 | ready;

    always_comb begin
        in_ready = 1'b1;
        case (control)
            2'b00:   in_ready = slot_free[0];
            2'b01:   in_ready = slot_free[1];
            2'b10:   in_ready = slot_free[2];
            default: in_ready = 1'b1;
        endcase
    end

    assign in_xfer = in_valid & in_ready;
    assign illegal = in_xfer & (control == 2'b11);

    // Stage p0 -> p1: slot capture and error logging.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= '0;
            for (int i = 0; i < 3; i++) data_p1[i] <= '0;
            err_p1 <= 1'b0;
            cnt_p1 <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (in_xfer && control == 2'(i)) begin
                    data_p1[i] <= in_data;
                    vld_p1[i]  <= 1'b1;
                end else if (vld_p1[i] && ready[i]) begin
                    vld_p1[i]  <= 1'b0;
                end
            end
            if (illegal) begin
                err_p1 <= 1'b1;
                cnt_p1 <= err_clear ? errcnt_width'(1) : sat_inc(cnt_p1);
            end else if (err_clear) begin
                err_p1 <= 1'b0;
                cnt_p1 <= '0;
            end
        end
    end

    assign out_valid1 = vld_p1[0];
    assign out_valid2 = vld_p1[1];
    assign out_valid3 = vld_p1[2];
    assign out_data1  = data_p1[0];
    assign out_data2  = data_p1[1];
    assign out_data3  = data_p1[2];
    assign err        = err_p1;
    assign err_count  = cnt_p1;

endmodule

// File: tb/tb_demultiplexer3_stream.sv
// Directed bench for demultiplexer3_stream: routing, back-pressure, independence,
// illegal-route logging with saturation, clear collision and mid-stream reset.
module tb_demultiplexer3_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  control = 2'b00;
    logic [31:0] in_data = '0;
    logic        out_valid1, out_valid2, out_valid3;
    logic        out_ready1 = 1'b0, out_ready2 = 1'b0, out_ready3 = 1'b0;
    logic [31:0] out_data1, out_data2, out_data3;
    logic        err;
    logic [7:0]  err_count;
    logic        err_clear = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    demultiplexer3_stream #(.width(32), .errcnt_width(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .control(control), .in_data(in_data),
        .out_valid1(out_valid1), .out_valid2(out_valid2), .out_valid3(out_valid3),
        .out_ready1(out_ready1), .out_ready2(out_ready2), .out_ready3(out_ready3),
        .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
        .err(err), .err_count(err_count), .err_clear(err_clear)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if ({out_valid1, out_valid2, out_valid3} !== 3'b000) begin fails++; $display("FAIL reset_valid got %b want 000", {out_valid1, out_valid2, out_valid3}); end
        tests++; if (out_data1 !== 32'h0) begin fails++; $display("FAIL reset_data1 got %h want 0", out_data1); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
        tests++; if (err_count !== 8'h00) begin fails++; $display("FAIL reset_cnt got %h want 00", err_count); end
    endtask

    task automatic test_basic();
        in_valid = 1'b1; control = 2'b01; in_data = 32'hDEADBEEF; out_ready2 = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid2 !== 1'b1) begin fails++; $display("FAIL basic_valid2 got %b want 1", out_valid2); end
        tests++; if (out_data2 !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_data2 got %h want deadbeef", out_data2); end
        tests++; if ({out_valid1, out_valid3} !== 2'b00) begin fails++; $display("FAIL basic_others got %b want 00", {out_valid1, out_valid3}); end
        tick();
        tests++; if (out_valid2 !== 1'b0) begin fails++; $display("FAIL basic_drain got %b want 0", out_valid2); end
        out_ready2 = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready1 = 1'b0;
        in_valid = 1'b1; control = 2'b00; in_data = 32'h11;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_first_ready got %b want 1", in_ready); end
        tick();
        in_data = 32'h22;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall_ready got %b want 0", in_ready); end
        tick();
        tests++; if (out_data1 !== 32'h11 || out_valid1 !== 1'b1) begin fails++; $display("FAIL bp_hold got %b/%h want 1/00000011", out_valid1, out_data1); end
        out_ready1 = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0; out_ready1 = 1'b0;
        tests++; if (out_data1 !== 32'h22 || out_valid1 !== 1'b1) begin fails++; $display("FAIL bp_second got %b/%h want 1/00000022", out_valid1, out_data1); end
    endtask

    task automatic test_independence();
        out_ready3 = 1'b0;
        in_valid = 1'b1; control = 2'b10; in_data = 32'h33;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL indep_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid3 !== 1'b1 || out_data3 !== 32'h33) begin fails++; $display("FAIL indep_slot3 got %b/%h want 1/00000033", out_valid3, out_data3); end
        tests++; if (out_valid1 !== 1'b1 || out_data1 !== 32'h22) begin fails++; $display("FAIL indep_slot1 got %b/%h want 1/00000022", out_valid1, out_data1); end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; control = 2'b11; in_data = 32'h55;
            #1;
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL illegal_ready[%0d] got %b want 1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        tests++; if (out_valid2 !== 1'b0) begin fails++; $display("FAIL illegal_slot2 got %b want 0", out_valid2); end
        tests++; if (out_data1 !== 32'h22 || out_data3 !== 32'h33) begin fails++; $display("FAIL illegal_slots got %h/%h want 22/33", out_data1, out_data3); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL illegal_err got %b want 1", err); end
        tests++; if (err_count !== 8'd3) begin fails++; $display("FAIL illegal_cnt got %0d want 3", err_count); end
        control = 2'b11;
        tick();
        tests++; if (err_count !== 8'd3) begin fails++; $display("FAIL illegal_novalid got %0d want 3", err_count); end
        in_valid = 1'b1;
        for (int i = 0; i < 260; i++) tick();
        in_valid = 1'b0;
        tests++; if (err_count !== 8'hFF) begin fails++; $display("FAIL illegal_sat got %h want ff", err_count); end
    endtask

    task automatic test_clear_collision();
        in_valid = 1'b1; control = 2'b11; err_clear = 1'b1;
        tick();
        in_valid = 1'b0;
        tests++; if (err !== 1'b1 || err_count !== 8'd1) begin fails++; $display("FAIL clr_collide got %b/%0d want 1/1", err, err_count); end
        tick();
        err_clear = 1'b0;
        tests++; if (err !== 1'b0 || err_count !== 8'd0) begin fails++; $display("FAIL clr_alone got %b/%0d want 0/0", err, err_count); end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; control = 2'b01; in_data = 32'h44;
        tick();
        in_valid = 1'b1; control = 2'b11;
        tick();
        tests++; if ({out_valid3, out_valid2, out_valid1} !== 3'b111 || err !== 1'b1) begin fails++; $display("FAIL mid_full got %b err %b want 111 err 1", {out_valid3, out_valid2, out_valid1}, err); end
        rst = 1'b1; in_valid = 1'b1; control = 2'b00; in_data = 32'h99;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        tests++; if ({out_valid3, out_valid2, out_valid1} !== 3'b000) begin fails++; $display("FAIL mid_valid got %b want 000", {out_valid3, out_valid2, out_valid1}); end
        tests++; if (out_data1 !== 32'h0 || out_data2 !== 32'h0 || out_data3 !== 32'h0) begin fails++; $display("FAIL mid_data got %h/%h/%h want 0/0/0", out_data1, out_data2, out_data3); end
        tests++; if (err !== 1'b0 || err_count !== 8'd0) begin fails++; $display("FAIL mid_err got %b/%0d want 0/0", err, err_count); end
        tick();
        tests++; if (out_valid1 !== 1'b0) begin fails++; $display("FAIL mid_not_captured got %b want 0", out_valid1); end
    endtask

    initial begin
        tick();
        test_reset();
        test_basic();
        test_backpressure();
        test_independence();
        test_illegal();
        test_clear_collision();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/demultiplexer3_stream.md
Name: demultiplexer3_stream

Overview:
- Registered 1-to-3 demultiplexer with valid/ready handshake. It is the distribution-side counterpart of the 3-input select used on the datapath.
- A single producer presents a word together with a 2-bit route code. The block steers the word into one of three independent one-entry output slots; each slot drains to its own consumer.
- Illegal route code 2'b11 is consumed and dropped, and is reported through a sticky error flag and a saturating counter.

Parameters:
- width, 32, data word width in bits.
- errcnt_width, 8, width of the illegal-route counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  producer presents a word this cycle.
- in_ready  output  1  block accepts the word this cycle.
- control  input  2  route code: 00=out1, 01=out2, 10=out3, 11=illegal.
- in_data  input  width  word to route.
- out_valid1/2/3  output  1 each  slot N holds a word.
- out_ready1/2/3  input  1 each  consumer N takes the word this cycle.
- out_data1/2/3  output  width each  slot N contents.
- err  output  1  sticky flag: an illegal route was accepted.
- err_count  output  errcnt_width  number of illegal routes accepted, saturating.
- err_clear  input  1  clears err and err_count.

Behaviour:
- Reset: on a rising clk edge with rst=1, all out_validN=0, all out_dataN=0, err=0, err_count=0. rst overrides every other input that cycle, and a word in flight is discarded.
- Transfer definitions:
  - Input transfer = in_valid & in_ready at a clock edge.
  - Output N transfer = out_validN & out_readyN at a clock edge.
- in_ready is combinational from control, the slot states and the out_ready inputs, never from in_valid:
  - control=00/01/10: in_ready = !out_validN | out_readyN, with N the addressed slot. A full slot that is draining this cycle can accept a new word in the same cycle.
  - control=11: in_ready=1.
- Latency: a word accepted at edge k appears on out_dataN with out_validN=1 right after edge k. Minimum one cycle, no combinational path from in_data to out_dataN.
- Slot N update each edge:
  - Input transfer routed to N: out_dataN <= in_data, out_validN <= 1. This wins over a simultaneous drain.
  - Otherwise, output N transfer: out_validN <= 0; out_dataN holds its value.
  - Otherwise: hold.
- Hold rule: while out_validN=1 and out_readyN=0, out_dataN is stable.
- Slots are independent. A stalled slot never blocks words routed to other slots. Full throughput is one word per cycle per route when the consumer is always ready.
- Illegal route: an input transfer with control=11 writes no slot. It sets err <= 1 and increments err_count, which saturates at 2^errcnt_width-1.
- err_clear=1 forces err <= 0 and err_count <= 0. If an illegal transfer happens in the same cycle, the illegal event wins: err <= 1, err_count <= 1.
- control and in_data are sampled only on an input transfer. Values while in_valid=0 are ignored, and control=11 with in_valid=0 has no effect.
- No internal state beyond the three slots and the error logic. No FSM encoding is exposed.

Test Plan:
1. Reset, then in_valid=1, control=01, in_data=0xDEADBEEF, out_ready2=1 → in_ready=1; next cycle out_valid2=1, out_data2=0xDEADBEEF, out_valid1=out_valid3=0; following cycle out_valid2=0.
2. Back-pressure:
   - Stimulus: out_ready1=0; send 0x11 to route 00, then 0x22 to route 00.
   - Required: second cycle in_ready=0 and out_data1 stays 0x11.
   - Then raise out_ready1=1: in_ready=1 that same cycle, next cycle out_data1=0x22 with out_valid1=1 and no bubble.
3. Independence: out_ready1=0 with slot 1 full; send 0x33 on route 10 → accepted, out_valid3=1, out_data3=0x33; slot 1 unchanged.
4. Illegal route and saturation:
   - Send control=11 with in_data=0x55 three times → in_ready=1 each time, no out_validN rises, err=1, err_count=3.
   - Preload via 255+ illegal sends → err_count stays at 0xFF.
5. Clear collision: assert err_clear with an illegal transfer in the same cycle → err=1, err_count=1. err_clear alone next cycle → err=0, err_count=0.
6. Reset mid-operation: all three slots full and stalled; assert rst for one cycle with in_valid=1, control=00 → all out_validN=0, out_dataN=0, err=0 after the edge; the word is not captured.
